// File: rtl/wb_host_pkg.sv
// Shared types and widths for the Wishbone host master slice.
package wb_host_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } state_e;

    // Wishbone addresses are word-granular; byte offset travels on sel.
    function automatic logic [WB_AW-1:0] word_align(input logic [WB_AW-1:0] adr);
        return adr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Counts unacknowledged bus cycles and flags the terminal cycle; an ack on that cycle suppresses expire.
module wb_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic expire
);

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_r;

    // Wait counter: cleared on command accept, advances per ack-less bus cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 16'd0;
        end else if (start) begin
            count_r <= 16'd0;
        end else if (active && !ack) begin
            count_r <= count_r + 16'd1;
        end
    end

    assign expire = active & ~ack & (count_r == LAST_COUNT);

endmodule

// File: rtl/wb_host_master.sv
// Single-transaction Wishbone classic initiator bridging a valid/ready command/response port.
// Optional bus timeout is built in when WB_HOST_MASTER_TIMEOUT_EN is defined.
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [WB_AW-1:0] cmd_adr_i,
    input  logic [WB_DW-1:0] cmd_dat_i,
    input  logic [WB_SW-1:0] cmd_sel_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WB_DW-1:0] rsp_dat_o,
    output logic             rsp_err_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [WB_SW-1:0] wbm_sel_o,
    output logic [WB_AW-1:0] wbm_adr_o,
    output logic [WB_DW-1:0] wbm_dat_o,
    input  logic [WB_DW-1:0] wbm_dat_i,
    input  logic             wbm_ack_i
);

    state_e           state_r;
    state_e           state_nxt_s;
    logic             ready_en_r;
    logic             cmd_we_r;
    logic [WB_AW-1:0] cmd_adr_r;
    logic [WB_DW-1:0] cmd_dat_r;
    logic [WB_SW-1:0] cmd_sel_r;
    logic [WB_DW-1:0] rsp_dat_r;
    logic             rsp_err_r;
    logic             accept_s;
    logic             bus_active_s;
    logic             expire_s;

    assign accept_s     = cmd_valid_i & cmd_ready_o;
    assign bus_active_s = (state_r == BUS);

`ifdef WB_HOST_MASTER_TIMEOUT_EN
    wb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n_i),
        .start  (accept_s),
        .active (bus_active_s),
        .ack    (wbm_ack_i),
        .expire (expire_s)
    );
`else
    assign expire_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Keeps cmd_ready low while reset is held and rises on the first edge after release.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Next-state logic; ack outside BUS is deliberately ignored.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = BUS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUS: begin
                if (wbm_ack_i || expire_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = BUS;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Command latch on accept; response capture on bus completion (ack wins over expire).
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cmd_we_r  <= 1'b0;
            cmd_adr_r <= 32'h0000_0000;
            cmd_dat_r <= 32'h0000_0000;
            cmd_sel_r <= 4'h0;
            rsp_dat_r <= 32'h0000_0000;
            rsp_err_r <= 1'b0;
        end else begin
            if (accept_s) begin
                cmd_we_r  <= cmd_we_i;
                cmd_adr_r <= cmd_adr_i;
                cmd_dat_r <= cmd_dat_i;
                cmd_sel_r <= cmd_sel_i;
            end
            if (bus_active_s && (wbm_ack_i || expire_s)) begin
                rsp_dat_r <= (wbm_ack_i && !cmd_we_r) ? wbm_dat_i : 32'h0000_0000;
                rsp_err_r <= ~wbm_ack_i;
            end
        end
    end

    // Output decode from state; bus fields read as zero whenever cyc is low.
    always_comb begin
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_dat_o   = 32'h0000_0000;
        rsp_err_o   = 1'b0;
        wbm_cyc_o   = 1'b0;
        wbm_stb_o   = 1'b0;
        wbm_we_o    = 1'b0;
        wbm_sel_o   = 4'h0;
        wbm_adr_o   = 32'h0000_0000;
        wbm_dat_o   = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                cmd_ready_o = ready_en_r;
            end
            BUS: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = cmd_we_r;
                wbm_sel_o = cmd_sel_r;
                wbm_adr_o = word_align(cmd_adr_r);
                wbm_dat_o = cmd_dat_r;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                rsp_dat_o   = rsp_dat_r;
                rsp_err_o   = rsp_err_r;
            end
            default: begin
                cmd_ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_host_master.sv
// Directed self-checking bench for wb_host_master; timeout cases need WB_HOST_MASTER_TIMEOUT_EN.
module tb_wb_host_master;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;
    logic        ack;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_host_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (dat_o),
        .wbm_dat_i   (dat_i),
        .wbm_ack_i   (ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic [31:0] e_adr, input logic e_we,
                             input logic [31:0] e_dat, input logic [3:0] e_sel);
        check_eq({tag, "_cyc"}, {31'd0, cyc}, 32'd1);
        check_eq({tag, "_stb"}, {31'd0, stb}, 32'd1);
        check_eq({tag, "_adr"}, adr, e_adr);
        check_eq({tag, "_we"}, {31'd0, we}, {31'd0, e_we});
        check_eq({tag, "_dat"}, dat_o, e_dat);
        check_eq({tag, "_sel"}, {28'd0, sel}, {28'd0, e_sel});
        check_eq({tag, "_rdy"}, {31'd0, cmd_ready}, 32'd0);
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] e_dat, input logic e_err);
        check_eq({tag, "_rvld"}, {31'd0, rsp_valid}, 32'd1);
        check_eq({tag, "_rdat"}, rsp_dat, e_dat);
        check_eq({tag, "_rerr"}, {31'd0, rsp_err}, {31'd0, e_err});
        check_eq({tag, "_cyc0"}, {30'd0, cyc, stb}, 32'd0);
        check_eq({tag, "_wedat0"}, dat_o | {31'd0, we}, 32'd0);
        check_eq({tag, "_rdy0"}, {31'd0, cmd_ready}, 32'd0);
    endtask

    // Offer a command at a negedge; it is accepted at the following posedge.
    task automatic issue(input logic i_we, input logic [31:0] i_adr,
                         input logic [31:0] i_dat, input logic [3:0] i_sel);
        check_eq("issue_rdy", {31'd0, cmd_ready}, 32'd1);
        cmd_we = i_we; cmd_adr = i_adr; cmd_dat = i_dat; cmd_sel = i_sel;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Hold ack low for 'waits' bus cycles, then ack once; check bus fields every cycle.
    task automatic respond(input string tag, input int waits, input logic [31:0] ack_dat,
                           input logic [31:0] e_adr, input logic e_we,
                           input logic [31:0] e_dat, input logic [3:0] e_sel);
        for (int i = 0; i <= waits; i++) begin
            check_bus(tag, e_adr, e_we, e_dat, e_sel);
            if (i == waits) begin
                ack = 1'b1;
                dat_i = ack_dat;
            end
            @(negedge clk);
        end
        ack = 1'b0;
        dat_i = 32'hDEAD_BEEF;
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq({tag, "_rvld0"}, {31'd0, rsp_valid}, 32'd0);
        check_eq({tag, "_rdy1"}, {31'd0, cmd_ready}, 32'd1);
        check_eq({tag, "_idle_cyc"}, {31'd0, cyc}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'd0; cmd_dat = 32'd0;
        cmd_sel = 4'd0; rsp_ready = 1'b0; dat_i = 32'd0; ack = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_rdy", {31'd0, cmd_ready}, 32'd0);
        check_eq("rst_cyc", {30'd0, cyc, stb}, 32'd0);
        check_eq("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        check_eq("rst_adr", adr, 32'd0);
        check_eq("rst_rdat", rsp_dat, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_rdy", {31'd0, cmd_ready}, 32'd1);

        // Spurious ack while idle.
        ack = 1'b1; dat_i = 32'h1111_1111;
        @(negedge clk);
        ack = 1'b0;
        check_eq("idle_ack_cyc", {31'd0, cyc}, 32'd0);
        check_eq("idle_ack_rvld", {31'd0, rsp_valid}, 32'd0);
        check_eq("idle_ack_rdy", {31'd0, cmd_ready}, 32'd1);

        // Write with one wait state.
        issue(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
        respond("wr", 1, 32'h5555_5555, 32'h3000_0004, 1'b1, 32'hA5A5_1234, 4'hF);
        check_rsp("wr", 32'h0000_0000, 1'b0);
        finish_rsp("wr");

        // Read of an unaligned address with three wait states.
        issue(1'b0, 32'h3000_0002, 32'h0000_0000, 4'hF);
        respond("rd", 3, 32'hCAFE_F00D, 32'h3000_0000, 1'b0, 32'h0000_0000, 4'hF);
        check_rsp("rd", 32'hCAFE_F00D, 1'b0);
        finish_rsp("rd");

        // Response back-pressure with a pending command and a spurious ack in RESP.
        issue(1'b0, 32'h0000_0100, 32'h0000_0000, 4'h3);
        respond("bp", 0, 32'h0BAD_CAFE, 32'h0000_0100, 1'b0, 32'h0000_0000, 4'h3);
        cmd_we = 1'b1; cmd_adr = 32'h0000_0040; cmd_dat = 32'h0000_0077; cmd_sel = 4'h1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_rsp("bp_hold", 32'h0BAD_CAFE, 1'b0);
            ack = (i == 2);
            dat_i = 32'h9999_9999;
            @(negedge clk);
        end
        ack = 1'b0;
        check_rsp("bp_after_ack", 32'h0BAD_CAFE, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("bp_rvld0", {31'd0, rsp_valid}, 32'd0);
        check_eq("bp_rdy_back", {31'd0, cmd_ready}, 32'd1);
        check_eq("bp_no_bus", {31'd0, cyc}, 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        respond("bp2", 0, 32'h4444_4444, 32'h0000_0040, 1'b1, 32'h0000_0077, 4'h1);
        check_rsp("bp2", 32'h0000_0000, 1'b0);
        finish_rsp("bp2");

        // Reset asserted in the second bus cycle.
        issue(1'b1, 32'h0000_0050, 32'h0000_0099, 4'hF);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mrst_cyc", {30'd0, cyc, stb}, 32'd0);
        check_eq("mrst_rdy", {31'd0, cmd_ready}, 32'd0);
        check_eq("mrst_adr", adr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mrst_no_rsp", {30'd0, rsp_valid, cyc}, 32'd0);
        end
        issue(1'b0, 32'h0000_0060, 32'h0000_0000, 4'hF);
        respond("mrst_rd", 0, 32'h1357_9BDF, 32'h0000_0060, 1'b0, 32'h0000_0000, 4'hF);
        check_rsp("mrst_rd", 32'h1357_9BDF, 1'b0);
        finish_rsp("mrst_rd");

`ifdef WB_HOST_MASTER_TIMEOUT_EN
        // No ack: bus held exactly TMO cycles then error response.
        issue(1'b0, 32'h0000_0070, 32'h0000_0000, 4'hF);
        for (int i = 0; i < TMO; i++) begin
            check_eq("tmo_cyc", {30'd0, cyc, stb}, 32'd3);
            @(negedge clk);
        end
        check_rsp("tmo", 32'h0000_0000, 1'b1);
        finish_rsp("tmo");

        // Ack on the terminal-count cycle wins.
        issue(1'b0, 32'h0000_0074, 32'h0000_0000, 4'hF);
        respond("tmo_ack", TMO - 1, 32'h2468_ACE0, 32'h0000_0074, 1'b0, 32'h0000_0000, 4'hF);
        check_rsp("tmo_ack", 32'h2468_ACE0, 1'b0);
        finish_rsp("tmo_ack");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_host_master.md
WB_HOST_MASTER -- requirements
Module: wb_host_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: bus cycles to wait for wbm_ack_i before abort (range 2..65535).
REQ-002 SHALL have port wb_clk_i, input, 1: sole clock; all logic samples on its rising edge.
REQ-003 SHALL have port wb_rst_n_i, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port cmd_valid_i, input, 1: command offered.
REQ-005 SHALL have port cmd_ready_o, output, 1: command accepted when high with cmd_valid_i.
REQ-006 SHALL have port cmd_we_i, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port cmd_adr_i, input, 32: byte address.
REQ-008 SHALL have port cmd_dat_i, input, 32: write data.
REQ-009 SHALL have port cmd_sel_i, input, 4: byte lane enables.
REQ-010 SHALL have port rsp_valid_o, output, 1: response available.
REQ-011 SHALL have port rsp_ready_i, input, 1: response consumed when high with rsp_valid_o.
REQ-012 SHALL have port rsp_dat_o, output, 32: read data (0 for writes and errors).
REQ-013 SHALL have port rsp_err_o, output, 1: transaction timed out.
REQ-014 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o (output, 1 each), wbm_sel_o (output, 4), wbm_adr_o (output, 32) and wbm_dat_o (output, 32): Wishbone classic initiator outputs.
REQ-015 SHALL have ports wbm_dat_i (input, 32) and wbm_ack_i (input, 1): Wishbone responder return signals.

Function
REQ-016 SHALL implement FSM states IDLE, BUS and RESP; cmd_ready_o = 1 only in IDLE.
REQ-017 IDLE -> BUS on cmd_valid_i & cmd_ready_o: latch we/adr/dat/sel; wbm_cyc_o = wbm_stb_o = 1 from the next cycle.
REQ-018 wbm_adr_o SHALL equal the latched address with bits [1:0] forced to 0.
REQ-019 In BUS, all wbm_* outputs SHALL remain stable until wbm_ack_i is sampled high.
REQ-020 BUS -> RESP on sampled wbm_ack_i: cyc/stb low the next cycle; capture wbm_dat_i for reads, 0 for writes; rsp_err_o = 0; rsp_valid_o = 1.
REQ-021 Minimum latency: handshake at edge N, stb high in cycle N+1, ack in N+1 gives rsp_valid_o high in cycle N+2.
REQ-022 RESP SHALL hold rsp_* stable until rsp_ready_i; RESP -> IDLE on handshake. cmd_ready_o returns high the following cycle.
REQ-023 wbm_ack_i SHALL be ignored in IDLE and RESP.
REQ-024 wbm_dat_o and wbm_we_o SHALL be 0 whenever wbm_cyc_o is 0.

Reset
REQ-025 wb_rst_n_i low SHALL immediately force IDLE and clear the latched command. Outputs: cmd_ready_o = 0 while reset is asserted, then 1; all other outputs 0.
REQ-026 Reset asserted mid-BUS SHALL drop wbm_cyc_o/wbm_stb_o asynchronously and produce no response.

Configuration
REQ-027 With macro WB_HOST_MASTER_TIMEOUT_EN defined: a counter SHALL clear on BUS entry and increment each BUS cycle without ack. On reaching TIMEOUT_CYCLES: drop cyc/stb, enter RESP with rsp_err_o = 1 and rsp_dat_o = 0.
REQ-028 An ack on the terminal-count cycle SHALL win (normal response).
REQ-029 Without WB_HOST_MASTER_TIMEOUT_EN: no counter; BUS waits indefinitely; rsp_err_o tied 0; TIMEOUT_CYCLES ignored.

Structure
REQ-030 Package wb_host_pkg SHALL hold the state enum (IDLE/BUS/RESP), WB_AW = 32, WB_DW = 32, WB_SW = 4.
REQ-031 Timeout logic SHALL be sub-module wb_timeout_ctr (start, ack, expire), instantiated only under the macro.

Verification
REQ-032 Write: cmd adr 0x3000_0004, dat 0xA5A5_1234, sel 0xF; responder acks after 1 cycle -> one stb pulse with stable fields; rsp_valid, dat 0, err 0.
REQ-033 Read: adr 0x3000_0002; ack after 3 waits with dat 0xCAFE_F00D -> wbm_adr_o 0x3000_0000; rsp_dat 0xCAFE_F00D.
REQ-034 Back-pressure: rsp_ready_i low 5 cycles -> rsp_* held; cmd_ready_o stays 0 until the handshake; no second bus cycle starts.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES = 8): no ack -> cyc drops after 8 BUS cycles; rsp_err 1, dat 0; ack on cycle 8 -> normal response.
REQ-036 Reset: wb_rst_n_i low in BUS cycle 2 -> cyc/stb 0 the same cycle; no rsp_valid; a new command after release completes normally.
REQ-037 Spurious ack in IDLE and in RESP -> no state change, no response.
